sha1_pipe_ctrl: RTL and testbench
=================================

SHA1_PIPE_CTRL -- requirements
Module: sha1_pipe_ctrl

Interface
REQ-001 Parameter: ROUNDS, 20, rounds per stage.
REQ-002 Parameter: NREQ, 2, number of requesters.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  NREQ  per-requester block request; held high until granted.
REQ-006 Port: gnt  output  NREQ  one-hot, one-cycle grant pulse; block accepted this cycle.
REQ-007 Port: feed  output  4  per-stage one-cycle load pulse (feed[0] to stage 0, feed[s] to stage s).
REQ-008 Port: blk_busy  output  4  per-stage busy, high while that stage runs rounds.
REQ-009 Port: blk_last_busy  output  4  blk_busy delayed one clock.
REQ-010 Port: rnd0..rnd3  output  5 each  current round index of each stage, 0..ROUNDS-1.
REQ-011 Port: done_valid  output  1  one-cycle pulse; final hash is valid on the datapath this cycle.
REQ-012 Port: done_tag  output  log2(NREQ)  requester id of the completed block, valid with done_valid.
REQ-013 Port: idle  output  1  high when no block is in any stage or pending output.

Function
REQ-014 Grant: SHALL grant only when blk_busy[0]=0 and feed[0]=0; at most one gnt bit is high per cycle.
REQ-015 Arbitration: SHALL be round-robin; priority pointer advances to the requester after the last granted one; with a single active requester, that requester wins every eligible cycle.
REQ-016 Stage 0 feed: feed[0] SHALL be high in cycle T+1 after a grant in cycle T.
REQ-017 Stage s>0 feed: feed[s] SHALL equal blk_last_busy[s-1] & ~blk_busy[s-1] (combinational on registered state).
REQ-018 Busy: blk_busy[s] SHALL rise the cycle after feed[s] and stay high exactly ROUNDS cycles; rnd_s SHALL be 0 in the first busy cycle and increment by 1 each cycle to ROUNDS-1.
REQ-019 Idle rounds: rnd_s SHALL hold 0 while blk_busy[s]=0.
REQ-020 Schedule: for a grant at cycle T, blk_busy[0] is high T+2..T+21, blk_busy[1] T+23..T+42, blk_busy[2] T+44..T+63, blk_busy[3] T+65..T+84.
REQ-021 Completion: done_valid SHALL pulse two cycles after the falling edge of blk_busy[3] (cycle T+87), aligned with the datapath hash-ready pulse.
REQ-022 Tags: each stage SHALL hold a tag register loaded on feed[s] from the stage s-1 tag (stage 0: granted id); done_tag SHALL be captured from the stage 3 tag on its falling edge and held through done_valid.
REQ-023 Back-to-back: a new grant is allowed in the cycle after blk_busy[0] falls; the minimum grant spacing is ROUNDS+2 cycles; stages SHALL never overlap.
REQ-024 Collision: a feed[s] arriving while blk_busy[s]=1 is a design-invariant violation; a simulation-only assertion SHALL flag it.
REQ-025 idle SHALL be low from the grant cycle through the done_valid cycle of the last block in flight.
REQ-026 Requests deasserted before a grant SHALL be ignored; gnt never asserts for a req bit that is low.

Reset
REQ-027 On reset: gnt, feed, blk_busy, blk_last_busy, rnd0..rnd3, done_valid and done_tag SHALL be 0, the round-robin pointer SHALL point to requester 0, and idle SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight blocks without emitting done_valid; the first grant is possible in the first cycle after reset deasserts.

Verification
REQ-029 Single block: req=01 at cycle 0 -> gnt=01 at 0, blk_busy[0] at 2..21, blk_busy[3] at 65..84, done_valid=1 with done_tag=0 at 87, idle=1 at 88.
REQ-030 Round count: during stage 2 of a block -> rnd2 steps 0..19 exactly once, and rnd0, rnd1 and rnd3 remain 0.
REQ-031 Fairness: req=11 held continuously -> grants alternate 0,1,0,1 at spacing 22 cycles; done_tag follows the same order; four done pulses.
REQ-032 Pipeline full: four back-to-back blocks -> all four blk_busy bits high simultaneously during one window, no collision assertion fires, and done pulses are spaced 22 cycles apart.
REQ-033 Reset mid-flight: reset at cycle 40 of a running block -> all outputs 0 immediately, no done_valid afterward; a new req at cycle 50 is granted at cycle 50.
REQ-034 Request withdrawal: req[1] pulsed for 1 cycle while stage 0 is busy -> no gnt[1]; req[0] held -> gnt=01 when stage 0 frees.

Source files
------------

// File: rtl/sha1_pipe_ctrl.sv
// ============================================================================
//  Module   : sha1_pipe_ctrl
//  Brief    : Four-stage SHA-1 round pipeline controller. Round-robin block
//             admission, per-stage round counters, tag tracking and
//             completion pulse aligned with the datapath hash-ready strobe.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sha1_pipe_ctrl #(
    parameter int ROUNDS = 20,
    parameter int NREQ   = 2,
    localparam int TAGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [3:0]      feed,
    output logic [3:0]      blk_busy,
    output logic [3:0]      blk_last_busy,
    output logic [4:0]      rnd0,
    output logic [4:0]      rnd1,
    output logic [4:0]      rnd2,
    output logic [4:0]      rnd3,
    output logic            done_valid,
    output logic [TAGW-1:0] done_tag,
    output logic            idle
);

    localparam int NSTG = 4;

    logic [TAGW-1:0]            r_ptr;
    logic [TAGW-1:0]            r_gnt_id;
    logic                       r_feed0;
    logic [NSTG-1:0]            r_last_busy;
    logic                       r_fall_d1;
    logic                       r_done_valid;
    logic [TAGW-1:0]            r_done_tag;

    logic [NREQ-1:0]            w_gnt;
    logic [TAGW-1:0]            w_gnt_id;
    logic [TAGW-1:0]            w_idx;
    logic                       w_gnt_any;
    logic [NSTG-1:0]            w_feed;
    logic [NSTG-1:0]            w_busy;
    logic [NSTG-1:0][4:0]       w_rnd;
    logic [NSTG-1:0][TAGW-1:0]  w_tag;
    logic                       w_fall3;

    // Round-robin pick: first requester at or after the pointer, only when
    // stage 0 is neither loading nor running. Reset suppresses any grant.
    always_comb begin
        w_gnt     = '0;
        w_gnt_id  = '0;
        w_idx     = '0;
        w_gnt_any = 1'b0;
        if (!reset && !w_busy[0] && !r_feed0) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = TAGW'((int'(r_ptr) + k) % NREQ);
                if (!w_gnt_any && req[w_idx]) begin
                    w_gnt_any    = 1'b1;
                    w_gnt_id     = w_idx;
                    w_gnt[w_idx] = 1'b1;
                end
            end
        end
    end

    // Pointer advance, stage-0 load pulse and captured requester id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_feed0  <= 1'b0;
            r_gnt_id <= '0;
        end else begin
            r_feed0 <= w_gnt_any;
            if (w_gnt_any) begin
                r_gnt_id <= w_gnt_id;
                r_ptr    <= (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;
            end
        end
    end

    assign w_feed[0] = r_feed0;

    generate
        for (genvar s = 0; s < NSTG; s++) begin : g_stage
            logic            r_busy_s;
            logic [4:0]      r_rnd_s;
            logic [TAGW-1:0] r_tag_s;
            logic [TAGW-1:0] w_tag_src;

            if (s == 0) begin : g_src0
                assign w_tag_src = r_gnt_id;
            end else begin : g_srcn
                // A stage loads the cycle its predecessor finishes.
                assign w_feed[s]  = r_last_busy[s-1] & ~w_busy[s-1];
                assign w_tag_src  = w_tag[s-1];
            end

            // Round counter runs 0..ROUNDS-1 while busy, parks at 0 otherwise.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_busy_s <= 1'b0;
                    r_rnd_s  <= '0;
                    r_tag_s  <= '0;
                end else if (w_feed[s]) begin
                    r_busy_s <= 1'b1;
                    r_rnd_s  <= '0;
                    r_tag_s  <= w_tag_src;
                end else if (r_busy_s) begin
                    if (r_rnd_s == 5'(ROUNDS - 1)) begin
                        r_busy_s <= 1'b0;
                        r_rnd_s  <= '0;
                    end else begin
                        r_rnd_s  <= r_rnd_s + 5'd1;
                    end
                end
            end

            assign w_busy[s] = r_busy_s;
            assign w_rnd[s]  = r_rnd_s;
            assign w_tag[s]  = r_tag_s;

`ifndef SYNTHESIS
            // A load into a running stage would corrupt its state.
            a_no_collision: assert property (@(posedge clk) disable iff (reset)
                !(w_feed[s] && w_busy[s]))
                else $error("stage %0d loaded while busy", s);
`endif
        end
    endgenerate

    assign w_fall3 = r_last_busy[3] & ~w_busy[3];

    // Busy history, and completion pulse two cycles after stage 3 drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_busy  <= '0;
            r_fall_d1    <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_tag   <= '0;
        end else begin
            r_last_busy  <= w_busy;
            r_fall_d1    <= w_fall3;
            r_done_valid <= r_fall_d1;
            if (w_fall3) begin
                r_done_tag <= w_tag[3];
            end
        end
    end

    assign gnt           = w_gnt;
    assign feed          = w_feed;
    assign blk_busy      = w_busy;
    assign blk_last_busy = r_last_busy;
    assign rnd0          = w_rnd[0];
    assign rnd1          = w_rnd[1];
    assign rnd2          = w_rnd[2];
    assign rnd3          = w_rnd[3];
    assign done_valid    = r_done_valid;
    assign done_tag      = r_done_tag;
    assign idle          = ~(w_gnt_any | (|w_feed) | (|w_busy) | w_fall3
                             | r_fall_d1 | r_done_valid);

endmodule

`default_nettype wire

// File: tb/tb_sha1_pipe_ctrl.sv
// ============================================================================
//  Module   : tb_sha1_pipe_ctrl
//  Brief    : Bench for sha1_pipe_ctrl. Stimulus records each expected grant;
//             a schedule model derives per-cycle outputs from the grant list
//             and a scoreboard matches completion pulses and tags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha1_pipe_ctrl;

    localparam int ROUNDS = 20;
    localparam int NREQ   = 2;
    localparam int DONE_D = 2 + 3 * (ROUNDS + 1) + ROUNDS + 2;  // 87

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [1:0] gnt;
    logic [3:0] feed, blk_busy, blk_last_busy;
    logic [4:0] rnd0, rnd1, rnd2, rnd3;
    logic       done_valid;
    logic [0:0] done_tag;
    logic       idle;

    sha1_pipe_ctrl #(.ROUNDS(ROUNDS), .NREQ(NREQ)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .gnt           (gnt),
        .feed          (feed),
        .blk_busy      (blk_busy),
        .blk_last_busy (blk_last_busy),
        .rnd0          (rnd0),
        .rnd1          (rnd1),
        .rnd2          (rnd2),
        .rnd3          (rnd3),
        .done_valid    (done_valid),
        .done_tag      (done_tag),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int tag;
    } ent_t;

    ent_t g_q[$];   // grants issued: cycle and requester id
    ent_t d_q[$];   // expected completions: cycle and tag

    int n_pass  = 0;
    int n_total = 0;
    bit seen_all4 = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    endtask

    // Schedule model: every output derived from cycle distance to each grant.
    always @(negedge clk) begin
        logic [1:0] eg;
        logic [3:0] ef, eb, elb;
        int         er[4];
        logic       ed, ei;
        int         d, st;
        eg = '0; ef = '0; eb = '0; elb = '0; ed = 1'b0; ei = 1'b1;
        for (int s = 0; s < 4; s++) er[s] = 0;
        if (!reset) begin
            foreach (g_q[i]) begin
                d = cyc - g_q[i].t;
                if (d == 0) eg[g_q[i].tag] = 1'b1;
                if (d >= 0 && d <= DONE_D) ei = 1'b0;
                if (d == DONE_D) ed = 1'b1;
                for (int s = 0; s < 4; s++) begin
                    st = 2 + (ROUNDS + 1) * s;
                    if (d == st - 1) ef[s] = 1'b1;
                    if (d >= st && d <= st + ROUNDS - 1) begin
                        eb[s] = 1'b1;
                        er[s] = d - st;
                    end
                    if (d >= st + 1 && d <= st + ROUNDS) elb[s] = 1'b1;
                end
            end
        end else begin
            chk("done_tag_reset", int'(done_tag), 0);
        end
        chk("gnt", int'(gnt), int'(eg));
        chk("feed", int'(feed), int'(ef));
        chk("blk_busy", int'(blk_busy), int'(eb));
        chk("blk_last_busy", int'(blk_last_busy), int'(elb));
        chk("rnd0", int'(rnd0), er[0]);
        chk("rnd1", int'(rnd1), er[1]);
        chk("rnd2", int'(rnd2), er[2]);
        chk("rnd3", int'(rnd3), er[3]);
        chk("done_valid", int'(done_valid), int'(ed));
        chk("idle", int'(idle), int'(ei));
        if (blk_busy == 4'hF) seen_all4 = 1'b1;
    end

    // Scoreboard: pop one expected completion per done pulse.
    always @(negedge clk) begin
        ent_t e;
        if (!reset && done_valid) begin
            if (d_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = d_q.pop_front();
                chk("done_tag", int'(done_tag), e.tag);
                chk("done_cycle", cyc, e.t);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_blk(input int tag);
        ent_t e;
        e.t = cyc; e.tag = tag;
        g_q.push_back(e);
        e.t = cyc + DONE_D;
        d_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        g_q.delete();
        d_q.delete();
        step(n);
        reset = 1'b0;
    endtask

    // Directed scenarios, each ending with the pipeline drained.
    initial begin
        step(3);
        reset = 1'b0;
        step(2);

        // Single block from requester 0
        req = 2'b01; expect_blk(0); step(1);
        req = 2'b00; step(92);

        // Fairness and full pipeline: both requesters held, pointer reset to 0
        do_reset(2);
        req = 2'b11;
        expect_blk(0); step(22);
        expect_blk(1); step(22);
        expect_blk(0); step(22);
        expect_blk(1); step(1);
        req = 2'b00; step(92);

        // Withdrawal: req[1] pulses while stage 0 is busy, req[0] held
        req = 2'b01; expect_blk(0); step(5);
        req = 2'b11; step(1);
        req = 2'b01; step(16);
        expect_blk(0); step(1);
        req = 2'b00; step(92);

        // Reset 40 cycles into a block, new request as reset releases
        req = 2'b01; expect_blk(0); step(1);
        req = 2'b00; step(39);
        do_reset(10);
        req = 2'b01; expect_blk(0); step(1);
        req = 2'b00; step(92);

        chk("all4_busy_seen", int'(seen_all4), 1);
        chk("done_queue_empty", d_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
